// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state type and byte-lane strobe helper.
// Used by ahb_slave_sram (sub-word support selected by AHB_SLV_SUBWORD_EN).
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_4WORD = 3'b100,
    HSIZE_8WORD = 3'b101,
    HSIZE_16W   = 3'b110,
    HSIZE_32W   = 3'b111
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    SLV_IDLE = 2'b00,
    SLV_WAIT = 2'b01,
    SLV_ERR1 = 2'b10,
    SLV_ERR2 = 2'b11
  } slv_state_e;

  // Byte enables for a little-endian 32-bit bus; wider sizes map to the full word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    strb = 4'b1111;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/ahb_slv_sram_array.sv
// 32-bit synchronous RAM: one byte-enabled write port and one registered read port on hclk.
// Each byte lane is its own narrow array so lane strobes map directly onto RAM write enables.
module ahb_slv_sram_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              hclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_be,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      // Read returns the pre-write contents when both ports hit the same word.
      always_ff @(posedge hclk) begin
        if (wr_en && wr_be[gi]) begin
          mem[wr_addr] <= wr_data[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_byte_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi*8 +: 8] = rd_byte_reg;
    end
  endgenerate

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB slave fronting an on-chip SRAM: wait states, two-cycle ERROR, read-after-write forwarding.
// Define AHB_SLV_SUBWORD_EN to allow byte/halfword transfers; otherwise non-word sizes error.
module ahb_slave_sram
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_DEPTH   = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);
  localparam logic [3:0]  WS_LOAD   = 4'(WAIT_STATES);

  slv_state_e        state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  hresp_e            hresp_st;

  logic              wr_pend_reg;
  logic [IDX_W-1:0]  wr_idx_reg;
  logic [3:0]        wr_be_reg;
  logic              rd_valid_reg;
  logic              fwd_hit_reg;
  logic [3:0]        fwd_be_reg;
  logic [31:0]       fwd_data_reg;

  logic [31:0]       offset;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_valid, acc_err, acc_ok, rd_acc, wr_commit;
  logic [3:0]        acc_be;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign unused_bits = ^hburst;

  // Unsigned subtraction makes addresses below BASE_ADDR land far out of range.
  assign offset  = haddr - BASE_ADDR;
  assign acc_idx = offset[IDX_W+1:2];

  // Accepts are only possible while this slave is showing hready_out=1 (IDLE or ERR2).
  assign acc_valid = hsel && hready && htrans[1] &&
                     ((state_reg == SLV_IDLE) || (state_reg == SLV_ERR2));

  always_comb begin
    acc_err = 1'b0;
    if (offset >= MEM_BYTES) begin
      acc_err = 1'b1;
    end
`ifdef AHB_SLV_SUBWORD_EN
    case (hsize)
      HSIZE_BYTE: ;
      HSIZE_HALF: if (haddr[0]) acc_err = 1'b1;
      HSIZE_WORD: if (haddr[1:0] != 2'b00) acc_err = 1'b1;
      default:    acc_err = 1'b1;
    endcase
`else
    if ((hsize != HSIZE_WORD) || (haddr[1:0] != 2'b00)) begin
      acc_err = 1'b1;
    end
`endif
  end

`ifdef AHB_SLV_SUBWORD_EN
  assign acc_be = byte_strobe(hsize, haddr[1:0]);
`else
  assign acc_be = 4'b1111;
`endif

  assign acc_ok    = acc_valid && !acc_err;
  assign rd_acc    = acc_ok && !hwrite;
  // A pending write retires on the edge that ends its hready_out=1 data-phase cycle.
  assign wr_commit = wr_pend_reg && (state_reg == SLV_IDLE);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_reg <= SLV_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hready_out = 1'b1;
    hresp_st   = HRESP_OKAY;
    case (state_reg)
      SLV_WAIT: begin
        hready_out = 1'b0;
        cnt_next   = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = SLV_IDLE;
        end
      end
      SLV_ERR1: begin
        hready_out = 1'b0;
        hresp_st   = HRESP_ERROR;
        state_next = SLV_ERR2;
      end
      SLV_ERR2: begin
        hresp_st   = HRESP_ERROR;
        state_next = SLV_IDLE;
      end
      default: ;
    endcase
    if (acc_valid) begin
      if (acc_err) begin
        state_next = SLV_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_next = SLV_WAIT;
        cnt_next   = WS_LOAD;
      end else begin
        state_next = SLV_IDLE;
      end
    end
  end

  assign hresp = hresp_st;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_pend_reg  <= 1'b0;
      wr_idx_reg   <= '0;
      wr_be_reg    <= 4'd0;
      rd_valid_reg <= 1'b0;
      fwd_hit_reg  <= 1'b0;
      fwd_be_reg   <= 4'd0;
      fwd_data_reg <= 32'd0;
    end else begin
      if (acc_ok && hwrite) begin
        wr_pend_reg <= 1'b1;
        wr_idx_reg  <= acc_idx;
        wr_be_reg   <= acc_be;
      end else if (wr_commit) begin
        wr_pend_reg <= 1'b0;
      end
      // RAM returns old contents on a same-edge hit, so remember the lanes being written.
      if (rd_acc) begin
        rd_valid_reg <= 1'b1;
        fwd_hit_reg  <= wr_commit && (wr_idx_reg == acc_idx);
        fwd_be_reg   <= wr_be_reg;
        fwd_data_reg <= hwdata;
      end
    end
  end

  ahb_slv_sram_array #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (IDX_W)
  ) u_array (
    .hclk    (hclk),
    .wr_en   (wr_commit && !hreset),
    .wr_addr (wr_idx_reg),
    .wr_be   (wr_be_reg),
    .wr_data (hwdata),
    .rd_en   (rd_acc),
    .rd_addr (acc_idx),
    .rd_data (rd_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rdata
      assign hrdata[gi*8 +: 8] = !rd_valid_reg ? 8'h00 :
                                 (fwd_hit_reg && fwd_be_reg[gi]) ? fwd_data_reg[gi*8 +: 8] :
                                 rd_data[gi*8 +: 8];
    end
  endgenerate

endmodule
